// File: rtl/exc_commit_ctrl_pkg.sv
// Shared CPU definitions: MIPS ExcCode values, exception vectors and the
// state encoding of the exception/ERET commit controller.
package cpu_defs;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] VEC_BEV  = 32'hBFC00380;
  localparam logic [31:0] VEC_NORM = 32'h80000180;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  function automatic logic [31:0] handler_vec(input logic bev);
    return bev ? VEC_BEV : VEC_NORM;
  endfunction

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Pipeline-side bundle of the exception commit controller. The redirect is a
// valid/ready handshake: redirect_valid and redirect_pc hold stable until a
// cycle with redirect_ready=1, which completes the transfer on that edge.
interface exc_commit_if;
  import cpu_defs::*;

  logic        exc_req;
  logic [4:0]  exc_code;
  logic        exc_badvaddr_valid;
  logic [31:0] exc_badvaddr;
  logic        eret_req;
  logic [31:0] vic_inst_addr;
  logic        vic_is_delayslot;
  logic [7:0]  exp_asid;
  logic        bev;
  logic        ie;
  logic [7:0]  im;
  logic [5:0]  hw_int;
  logic [1:0]  sw_int;
  logic        redirect_ready;

  logic        status_exl;
  logic [31:0] epc;
  logic        cause_bd;
  logic [4:0]  cause_exccode;
  logic [31:0] badvaddr;
  logic [7:0]  exc_asid;
  logic        int_pending;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  exc_state_e  dbg_state;

  modport master (
    output exc_req, exc_code, exc_badvaddr_valid, exc_badvaddr, eret_req,
           vic_inst_addr, vic_is_delayslot, exp_asid, bev, ie, im, hw_int,
           sw_int, redirect_ready,
    input  status_exl, epc, cause_bd, cause_exccode, badvaddr, exc_asid,
           int_pending, flush, redirect_valid, redirect_pc, busy, dbg_state
  );

  modport slave (
    input  exc_req, exc_code, exc_badvaddr_valid, exc_badvaddr, eret_req,
           vic_inst_addr, vic_is_delayslot, exp_asid, bev, ie, im, hw_int,
           sw_int, redirect_ready,
    output status_exl, epc, cause_bd, cause_exccode, badvaddr, exc_asid,
           int_pending, flush, redirect_valid, redirect_pc, busy, dbg_state
  );

endinterface

// File: rtl/exc_commit_ctrl.sv
// Exception/ERET commit controller: updates the exception CP0 fields, flushes
// the pipeline and holds a PC redirect until IF accepts it.
module exc_commit_ctrl
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  exc_commit_if.slave bus
);

  exc_state_e  state_q, state_d;
  logic        exl_q, exl_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [7:0]  asid_q, asid_d;
  logic        int_pending_q, int_pending_d;
  logic        flush_q, flush_d;
  logic        rv_q, rv_d;
  logic [31:0] target_q, target_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      exl_q         <= 1'b1;
      epc_q         <= '0;
      bd_q          <= 1'b0;
      code_q        <= '0;
      badvaddr_q    <= '0;
      asid_q        <= '0;
      int_pending_q <= 1'b0;
      flush_q       <= 1'b0;
      rv_q          <= 1'b0;
      target_q      <= '0;
    end else begin
      state_q       <= state_d;
      exl_q         <= exl_d;
      epc_q         <= epc_d;
      bd_q          <= bd_d;
      code_q        <= code_d;
      badvaddr_q    <= badvaddr_d;
      asid_q        <= asid_d;
      int_pending_q <= int_pending_d;
      flush_q       <= flush_d;
      rv_q          <= rv_d;
      target_q      <= target_d;
    end
  end

  // Requests arriving outside IDLE belong to instructions being flushed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (bus.exc_req || bus.eret_req) state_d = ST_FLUSH;
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: if (bus.redirect_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exl_d      = exl_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    code_d     = code_q;
    badvaddr_d = badvaddr_q;
    asid_d     = asid_q;
    flush_d    = flush_q;
    rv_d       = rv_q;
    target_d   = target_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.exc_req) begin
          // A nested exception keeps the EPC/BD of the original victim.
          if (!exl_q) begin
            epc_d = bus.vic_inst_addr;
            bd_d  = bus.vic_is_delayslot;
          end
          code_d   = bus.exc_code;
          asid_d   = bus.exp_asid;
          exl_d    = 1'b1;
          if (bus.exc_badvaddr_valid) badvaddr_d = bus.exc_badvaddr;
          target_d = handler_vec(bus.bev);
          flush_d  = 1'b1;
        end else if (bus.eret_req) begin
          exl_d    = 1'b0;
          target_d = epc_q;
          flush_d  = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_d = 1'b1;
        rv_d    = 1'b1;
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) begin
          flush_d = 1'b0;
          rv_d    = 1'b0;
        end
      end
      default: begin
        flush_d = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  assign int_pending_d = (|({bus.hw_int, bus.sw_int} & bus.im)) & bus.ie & ~exl_q
                         & (state_q == ST_IDLE);

  assign bus.status_exl     = exl_q;
  assign bus.epc            = epc_q;
  assign bus.cause_bd       = bd_q;
  assign bus.cause_exccode  = code_q;
  assign bus.badvaddr       = badvaddr_q;
  assign bus.exc_asid       = asid_q;
  assign bus.int_pending    = int_pending_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = target_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: exception, ERET, nesting, priority,
// interrupt-pending and reset-in-REDIRECT scenarios with hand-computed values.
module tb_exc_commit_ctrl;
  import cpu_defs::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exc_commit_if bus ();

  exc_commit_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.exc_req            = 1'b0;
    bus.exc_code           = 5'd0;
    bus.exc_badvaddr_valid = 1'b0;
    bus.exc_badvaddr       = 32'h0;
    bus.eret_req           = 1'b0;
    bus.vic_inst_addr      = 32'h0;
    bus.vic_is_delayslot   = 1'b0;
    bus.exp_asid           = 8'h0;
  endtask

  // ERET with redirect_ready high: expects redirect to exp_pc, 3-cycle turnaround.
  task automatic do_eret(input logic [31:0] exp_pc, input string tag);
    bus.eret_req       = 1'b1;
    bus.redirect_ready = 1'b1;
    tick();
    bus.eret_req = 1'b0;
    chk({tag, "_exl"}, {31'b0, bus.status_exl}, 32'd0);
    chk({tag, "_flush"}, {31'b0, bus.flush}, 32'd1);
    tick();
    chk({tag, "_rv"}, {31'b0, bus.redirect_valid}, 32'd1);
    chk({tag, "_pc"}, bus.redirect_pc, exp_pc);
    tick();
    chk({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    bus.bev            = 1'b0;
    bus.ie             = 1'b0;
    bus.im             = 8'h0;
    bus.hw_int         = 6'h0;
    bus.sw_int         = 2'h0;
    bus.redirect_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_exl", {31'b0, bus.status_exl}, 32'd1);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_code", {27'b0, bus.cause_exccode}, 32'd0);
    chk("rst_flush", {31'b0, bus.flush}, 32'd0);
    chk("rst_rv", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rst_pc", bus.redirect_pc, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_intp", {31'b0, bus.int_pending}, 32'd0);
    rst = 1'b0;
    tick();

    // Clear EXL so the next exception records its EPC (redirect to EPC=0)
    do_eret(32'h0, "eret0");

    // Syscall, not in a delay slot, BEV=1
    bus.exc_req          = 1'b1;
    bus.exc_code         = EXC_SYS;
    bus.vic_inst_addr    = 32'hBFC00100;
    bus.vic_is_delayslot = 1'b0;
    bus.exp_asid         = 8'h5A;
    bus.bev              = 1'b1;
    bus.redirect_ready   = 1'b1;
    tick();
    idle_inputs();
    chk("sys_epc", bus.epc, 32'hBFC00100);
    chk("sys_bd", {31'b0, bus.cause_bd}, 32'd0);
    chk("sys_code", {27'b0, bus.cause_exccode}, 32'd8);
    chk("sys_exl", {31'b0, bus.status_exl}, 32'd1);
    chk("sys_asid", {24'b0, bus.exc_asid}, 32'h5A);
    chk("sys_badv", bus.badvaddr, 32'h0);
    chk("sys_flush_n1", {31'b0, bus.flush}, 32'd1);
    chk("sys_rv_n1", {31'b0, bus.redirect_valid}, 32'd0);
    tick();
    chk("sys_rv_n2", {31'b0, bus.redirect_valid}, 32'd1);
    chk("sys_pc_n2", bus.redirect_pc, 32'hBFC00380);
    tick();
    chk("sys_busy_n3", {31'b0, bus.busy}, 32'd0);
    chk("sys_flush_n3", {31'b0, bus.flush}, 32'd0);
    chk("sys_rv_n3", {31'b0, bus.redirect_valid}, 32'd0);

    do_eret(32'hBFC00100, "eret1");

    // AdEL in a delay slot, BEV=0; then an ignored exc_req during REDIRECT
    bus.exc_req            = 1'b1;
    bus.exc_code           = EXC_ADEL;
    bus.vic_inst_addr      = 32'h80001004;
    bus.vic_is_delayslot   = 1'b1;
    bus.exc_badvaddr_valid = 1'b1;
    bus.exc_badvaddr       = 32'h00000003;
    bus.exp_asid           = 8'h11;
    bus.bev                = 1'b0;
    bus.redirect_ready     = 1'b0;
    tick();
    idle_inputs();
    chk("adel_epc", bus.epc, 32'h80001004);
    chk("adel_bd", {31'b0, bus.cause_bd}, 32'd1);
    chk("adel_badv", bus.badvaddr, 32'h3);
    chk("adel_code", {27'b0, bus.cause_exccode}, 32'd4);
    tick();
    chk("adel_pc", bus.redirect_pc, 32'h80000180);
    bus.exc_req          = 1'b1;
    bus.exc_code         = EXC_OV;
    bus.vic_inst_addr    = 32'h12345678;
    bus.vic_is_delayslot = 1'b0;
    tick();
    idle_inputs();
    chk("ign_code", {27'b0, bus.cause_exccode}, 32'd4);
    chk("ign_epc", bus.epc, 32'h80001004);
    chk("ign_rv", {31'b0, bus.redirect_valid}, 32'd1);
    chk("ign_pc", bus.redirect_pc, 32'h80000180);
    bus.redirect_ready = 1'b1;
    tick();
    chk("ign_idle", {31'b0, bus.busy}, 32'd0);

    // Nested exception with EXL=1: EPC/BD kept, ExcCode updated
    bus.exc_req          = 1'b1;
    bus.exc_code         = EXC_RI;
    bus.vic_inst_addr    = 32'h80000200;
    bus.vic_is_delayslot = 1'b0;
    tick();
    idle_inputs();
    chk("nest_epc", bus.epc, 32'h80001004);
    chk("nest_bd", {31'b0, bus.cause_bd}, 32'd1);
    chk("nest_code", {27'b0, bus.cause_exccode}, 32'd10);
    chk("nest_badv", bus.badvaddr, 32'h3);
    tick();
    chk("nest_pc", bus.redirect_pc, 32'h80000180);
    tick();

    // ERET with redirect_ready low for 3 cycles
    bus.eret_req       = 1'b1;
    bus.redirect_ready = 1'b0;
    tick();
    bus.eret_req = 1'b0;
    chk("eretw_exl", {31'b0, bus.status_exl}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("eretw_rv_hold", {31'b0, bus.redirect_valid}, 32'd1);
      chk("eretw_pc_hold", bus.redirect_pc, 32'h80001004);
      chk("eretw_flush_hold", {31'b0, bus.flush}, 32'd1);
      tick();
    end
    bus.redirect_ready = 1'b1;
    chk("eretw_rv_acc", {31'b0, bus.redirect_valid}, 32'd1);
    chk("eretw_pc_acc", bus.redirect_pc, 32'h80001004);
    tick();
    chk("eretw_idle", {31'b0, bus.busy}, 32'd0);
    chk("eretw_rv_off", {31'b0, bus.redirect_valid}, 32'd0);

    // exc_req and eret_req together: exception wins
    bus.exc_req          = 1'b1;
    bus.eret_req         = 1'b1;
    bus.exc_code         = EXC_BP;
    bus.vic_inst_addr    = 32'h80002000;
    bus.vic_is_delayslot = 1'b0;
    bus.bev              = 1'b1;
    tick();
    idle_inputs();
    chk("prio_exl", {31'b0, bus.status_exl}, 32'd1);
    chk("prio_epc", bus.epc, 32'h80002000);
    chk("prio_code", {27'b0, bus.cause_exccode}, 32'd9);
    tick();
    chk("prio_pc", bus.redirect_pc, 32'hBFC00380);
    tick();

    do_eret(32'h80002000, "eret2");

    // Interrupt pending
    bus.hw_int = 6'b000001;
    bus.im     = 8'h04;
    bus.ie     = 1'b1;
    tick();
    chk("int_set", {31'b0, bus.int_pending}, 32'd1);
    bus.im = 8'h08;
    tick();
    chk("int_masked", {31'b0, bus.int_pending}, 32'd0);
    bus.im = 8'h04;
    tick();
    chk("int_reset", {31'b0, bus.int_pending}, 32'd1);
    bus.exc_req          = 1'b1;
    bus.exc_code         = EXC_INT;
    bus.vic_inst_addr    = 32'h80003000;
    bus.bev              = 1'b0;
    bus.redirect_ready   = 1'b0;
    tick();
    idle_inputs();
    chk("int_exl_set", {31'b0, bus.status_exl}, 32'd1);
    chk("int_lag", {31'b0, bus.int_pending}, 32'd1);
    tick();
    chk("int_forced_low", {31'b0, bus.int_pending}, 32'd0);
    chk("int_rv", {31'b0, bus.redirect_valid}, 32'd1);

    // Reset while in REDIRECT
    rst = 1'b1;
    tick();
    chk("rstr_rv", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rstr_busy", {31'b0, bus.busy}, 32'd0);
    chk("rstr_flush", {31'b0, bus.flush}, 32'd0);
    chk("rstr_exl", {31'b0, bus.status_exl}, 32'd1);
    chk("rstr_epc", bus.epc, 32'h0);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
